// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter and the hazard unit:
// arbiter FSM states and the mem_state status encodings.
package mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT_IF,
      ST_GRANT_D,
      ST_WAIT_IF,
      ST_WAIT_D
   } arb_state_t;

   localparam logic [1:0] MEM_ST_IDLE  = 2'b00;
   localparam logic [1:0] MEM_ST_PEND  = 2'b01;
   localparam logic [1:0] MEM_ST_GRANT = 2'b10;
   localparam logic [1:0] MEM_ST_WAIT  = 2'b11;

   // Data wins unless fetch is also waiting and data owned the bus last.
   function automatic logic pick_data(input logic if_req, input logic d_req,
                                      input logic last_d);
      return d_req && !(if_req && last_d);
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction watchdog: down-counter loaded with LIMIT on clr, decremented
// while en, expire asserted at terminal count zero.
module mem_arb_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= CNT_W'(LIMIT);
      end else if (en && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between fetch and data.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | no transaction; capture winner of pending requests
// ST_GRANT_IF | fetch request on bus, waiting for bus_gnt
// ST_GRANT_D  | data request on bus, waiting for bus_gnt
// ST_WAIT_IF  | fetch accepted, waiting for bus_rvalid
// ST_WAIT_D   | data accepted, waiting for bus_rvalid
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_ready,
   output logic                if_rvalid,
   output logic [31:0]         if_rdata,
   output logic                if_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_ready,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_err,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wstrb,
   input  logic                bus_gnt,
   input  logic                bus_rvalid,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic [1:0]          mem_state
);

   arb_state_t state;
   logic       last_d;
   logic       grant_d;
   logic       is_idle;
   logic       in_txn;
   logic       owner_d;
   logic       resp_if;
   logic       resp_d;
   logic       resp_any;
   logic       tmo;

   assign is_idle  = (state == ST_IDLE);
   assign in_txn   = !is_idle;
   assign owner_d  = (state == ST_GRANT_D) || (state == ST_WAIT_D);
   assign grant_d  = pick_data(if_req, d_req, last_d);
   assign resp_if  = (state == ST_WAIT_IF) && bus_rvalid;
   assign resp_d   = (state == ST_WAIT_D) && bus_rvalid;
   assign resp_any = resp_if || resp_d;

`ifdef MEM_ARB_TIMEOUT_EN
   logic tmr_expire;

   mem_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (is_idle),
      .en     (in_txn),
      .expire (tmr_expire)
   );

   // A real response in the expiry cycle wins over the timeout.
   assign tmo = tmr_expire && in_txn && !resp_any;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign tmo = 1'b0;
`endif

   assign if_ready  = !rst && is_idle && if_req && !grant_d;
   assign d_ready   = !rst && is_idle && grant_d;
   assign if_rvalid = resp_if || (tmo && !owner_d);
   assign d_rvalid  = resp_d || (tmo && owner_d);
   assign if_err    = tmo && !owner_d;
   assign d_err     = tmo && owner_d;
   assign if_rdata  = resp_if ? bus_rdata[31:0] : 32'd0;
   assign d_rdata   = resp_d ? bus_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         last_d    <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_d) begin
                  bus_req   <= 1'b1;
                  bus_we    <= d_we;
                  bus_addr  <= d_addr;
                  bus_wdata <= d_wdata;
                  bus_wstrb <= d_wstrb;
                  state     <= ST_GRANT_D;
               end else if (if_req) begin
                  bus_req   <= 1'b1;
                  bus_we    <= 1'b0;
                  bus_addr  <= if_addr;
                  bus_wdata <= '0;
                  bus_wstrb <= '0;
                  state     <= ST_GRANT_IF;
               end
            end
            ST_GRANT_IF, ST_GRANT_D: begin
               if (tmo) begin
                  bus_req <= 1'b0;
                  last_d  <= owner_d;
                  state   <= ST_IDLE;
               end else if (bus_gnt) begin
                  bus_req <= 1'b0;
                  state   <= owner_d ? ST_WAIT_D : ST_WAIT_IF;
               end
            end
            ST_WAIT_IF, ST_WAIT_D: begin
               if (resp_any || tmo) begin
                  last_d <= owner_d;
                  state  <= ST_IDLE;
               end
            end
            default: begin
               bus_req <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      mem_state = MEM_ST_IDLE;
      if (!rst && !d_rvalid) begin
         case (state)
            ST_GRANT_D: mem_state = MEM_ST_GRANT;
            ST_WAIT_D:  mem_state = MEM_ST_WAIT;
            default:    mem_state = d_req ? MEM_ST_PEND : MEM_ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter: per-cycle input/expected rows
// plus hand-written reset and (with MEM_ARB_TIMEOUT_EN) watchdog sequences.
module tb_mem_arbiter;

   localparam int TB_TIMEOUT = 8;

   typedef struct packed {
      logic        if_ready;
      logic        if_rvalid;
      logic        if_err;
      logic [31:0] if_rdata;
      logic        d_ready;
      logic        d_rvalid;
      logic        d_err;
      logic [63:0] d_rdata;
      logic        bus_req;
      logic        bus_we;
      logic [63:0] bus_addr;
      logic [63:0] bus_wdata;
      logic [7:0]  bus_wstrb;
      logic [1:0]  mem_state;
   } outs_t;

   typedef struct {
      string       nm;
      logic        ir;
      logic [63:0] ia;
      logic        dr;
      logic        dwe;
      logic [63:0] da;
      logic [63:0] dwd;
      logic [7:0]  dws;
      logic        gnt;
      logic        rv;
      logic [63:0] rd;
      outs_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_ready, if_rvalid, if_err;
   logic [63:0] if_addr;
   logic [31:0] if_rdata;
   logic        d_req, d_we, d_ready, d_rvalid, d_err;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic [7:0]  d_wstrb;
   logic        bus_req, bus_we, bus_gnt, bus_rvalid;
   logic [63:0] bus_addr, bus_wdata, bus_rdata;
   logic [7:0]  bus_wstrb;
   logic [1:0]  mem_state;
   outs_t       act;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .mem_state(mem_state)
   );

   assign act = {if_ready, if_rvalid, if_err, if_rdata, d_ready, d_rvalid, d_err,
                 d_rdata, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, mem_state};

   function automatic outs_t o(logic iry, logic irv, logic [31:0] ird, logic dry,
                               logic drv, logic [63:0] drd, logic breq, logic bwe,
                               logic [63:0] ba, logic [63:0] bwd, logic [7:0] bws,
                               logic [1:0] ms);
      return {iry, irv, 1'b0, ird, dry, drv, 1'b0, drd, breq, bwe, ba, bwd, bws, ms};
   endfunction

   function automatic void add(string nm, logic ir, logic [63:0] ia, logic dr,
                               logic dwe, logic [63:0] da, logic [63:0] dwd,
                               logic [7:0] dws, logic gnt, logic rv,
                               logic [63:0] rd, outs_t exp);
      vec_t v;
      v.nm = nm; v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da;
      v.dwd = dwd; v.dws = dws; v.gnt = gnt; v.rv = rv; v.rd = rd; v.exp = exp;
      tbl.push_back(v);
   endfunction

   task automatic drive(vec_t v);
      if_req = v.ir; if_addr = v.ia;
      d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd; d_wstrb = v.dws;
      bus_gnt = v.gnt; bus_rvalid = v.rv; bus_rdata = v.rd;
   endtask

   task automatic chk(string nm, outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic chk_val(string nm, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] wd;
      logic [63:0] wa;
      wd = 64'hA5A5_A5A5_A5A5_A5A5;
      wa = 64'h8000_0000;

      // fetch only
      add("if_cap",    1, 64'h1000, 0,0,0,0,0, 0,0,0, o(1,0,0, 0,0,0, 0,0,0,0,0, 2'b00));
      add("if_grant",  0, 0, 0,0,0,0,0, 1,0,0,      o(0,0,0, 0,0,0, 1,0,64'h1000,0,0, 2'b00));
      add("if_wait",   0, 0, 0,0,0,0,0, 0,0,0,      o(0,0,0, 0,0,0, 0,0,64'h1000,0,0, 2'b00));
      add("if_resp",   0, 0, 0,0,0,0,0, 0,1,64'hDEAD_BEEF_0000_0013,
                                                    o(0,1,32'h13, 0,0,0, 0,0,64'h1000,0,0, 2'b00));
      // both pending, last grant fetch -> data first
      add("both_d_wins", 1, 64'h2000, 1,0,64'h3000,0,8'hFF, 0,0,0,
                                                    o(0,0,0, 1,0,0, 0,0,64'h1000,0,0, 2'b01));
      add("d_grant",   1, 64'h2000, 0,0,0,0,0, 1,0,0,
                                                    o(0,0,0, 0,0,0, 1,0,64'h3000,0,8'hFF, 2'b10));
      add("d_resp",    1, 64'h2000, 0,0,0,0,0, 0,1,64'h1122_3344_5566_7788,
                                                    o(0,0,0, 0,1,64'h1122_3344_5566_7788, 0,0,64'h3000,0,8'hFF, 2'b00));
      // both pending, last grant data -> fetch first; data write waits behind it
      add("both_if_wins", 1, 64'h2000, 1,1,wa,wd,8'h0F, 0,0,0,
                                                    o(1,0,0, 0,0,0, 0,0,64'h3000,0,8'hFF, 2'b01));
      add("if_grant2", 0, 0, 1,1,wa,wd,8'h0F, 1,0,0, o(0,0,0, 0,0,0, 1,0,64'h2000,0,0, 2'b01));
      add("if_wait2",  0, 0, 1,1,wa,wd,8'h0F, 0,0,0, o(0,0,0, 0,0,0, 0,0,64'h2000,0,0, 2'b01));
      add("if_resp2",  0, 0, 1,1,wa,wd,8'h0F, 0,1,64'h0000_0000_CAFE_F00D,
                                                    o(0,1,32'hCAFE_F00D, 0,0,0, 0,0,64'h2000,0,0, 2'b01));
      add("dw_cap",    0, 0, 1,1,wa,wd,8'h0F, 0,0,0, o(0,0,0, 1,0,0, 0,0,64'h2000,0,0, 2'b01));
      add("dw_grant0", 0, 0, 0,0,0,0,0, 0,0,0,      o(0,0,0, 0,0,0, 1,1,wa,wd,8'h0F, 2'b10));
      add("dw_grant1", 0, 0, 0,0,0,0,0, 1,0,0,      o(0,0,0, 0,0,0, 1,1,wa,wd,8'h0F, 2'b10));
      add("dw_wait",   0, 0, 0,0,0,0,0, 0,0,0,      o(0,0,0, 0,0,0, 0,1,wa,wd,8'h0F, 2'b11));
      add("dw_ack",    0, 0, 0,0,0,0,0, 0,1,0,      o(0,0,0, 0,1,0, 0,1,wa,wd,8'h0F, 2'b00));
      add("stray_rv_idle", 0, 0, 0,0,0,0,0, 0,1,64'hFFFF_FFFF_FFFF_FFFF,
                                                    o(0,0,0, 0,0,0, 0,1,wa,wd,8'h0F, 2'b00));
      // anti-starvation again, then bus_gnt delayed 5 cycles
      add("both_if_wins2", 1, 64'h5000, 1,0,64'h6000,0,8'hFF, 0,0,0,
                                                    o(1,0,0, 0,0,0, 0,1,wa,wd,8'h0F, 2'b01));
      for (int i = 0; i < 5; i++)
         add($sformatf("gnt_delay%0d", i), 0, 0, 1,0,64'h6000,0,8'hFF, 0, (i == 1), 64'h55,
             o(0,0,0, 0,0,0, 1,0,64'h5000,0,0, 2'b01));
      add("gnt_late",  0, 0, 1,0,64'h6000,0,8'hFF, 1,0,0,
                                                    o(0,0,0, 0,0,0, 1,0,64'h5000,0,0, 2'b01));
      add("if_resp3",  0, 0, 1,0,64'h6000,0,8'hFF, 0,1,64'h77,
                                                    o(0,1,32'h77, 0,0,0, 0,0,64'h5000,0,0, 2'b01));
      add("dr_cap",    0, 0, 1,0,64'h6000,0,8'hFF, 0,0,0,
                                                    o(0,0,0, 1,0,0, 0,0,64'h5000,0,0, 2'b01));
      add("dr_grant",  0, 0, 0,0,0,0,0, 1,0,0,      o(0,0,0, 0,0,0, 1,0,64'h6000,0,8'hFF, 2'b10));
      add("dr_resp",   0, 0, 0,0,0,0,0, 0,1,64'h99, o(0,0,0, 0,1,64'h99, 0,0,64'h6000,0,8'hFF, 2'b00));
      // leave a data read in WAIT_D for the reset sequence
      add("dr2_cap",   0, 0, 1,0,64'h7000,0,8'hFF, 0,0,0,
                                                    o(0,0,0, 1,0,0, 0,0,64'h6000,0,8'hFF, 2'b01));
      add("dr2_grant", 0, 0, 0,0,0,0,0, 1,0,0,      o(0,0,0, 0,0,0, 1,0,64'h7000,0,8'hFF, 2'b10));
      add("dr2_wait",  0, 0, 0,0,0,0,0, 0,0,0,      o(0,0,0, 0,0,0, 0,0,64'h7000,0,8'hFF, 2'b11));

      rst = 1'b1;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      d_wstrb = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("reset_state", '0);

      foreach (tbl[i]) begin
         @(posedge clk);
         #1 drive(tbl[i]);
         @(negedge clk);
         chk(tbl[i].nm, tbl[i].exp);
      end

      // asynchronous reset in WAIT_D with requests and a response present
      @(posedge clk);
      #1 if_req = 1; d_req = 1; d_addr = 64'h7000; bus_rvalid = 1; bus_rdata = 64'h1234;
      rst = 1'b1;
      #1 chk("rst_async_zero", '0);
      @(negedge clk);
      rst = 1'b0;
      if_req = 0; d_req = 0;
      #1 chk("stray_rv_after_rst", '0);
      @(posedge clk);
      #1 bus_rvalid = 0; if_req = 1; if_addr = 64'hA000; d_req = 1; d_addr = 64'hB000;
      @(negedge clk);
      chk("rst_clears_last", o(0,0,0, 1,0,0, 0,0,0,0,0, 2'b01));
      @(posedge clk);
      #1 if_req = 0; d_req = 0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
      // slave accepts but never responds
      @(posedge clk);
      #1 d_req = 1; d_we = 0; d_addr = 64'h9000;
      @(negedge clk);
      chk_val("tmo_cap", {63'd0, d_ready}, 64'd1);
      @(posedge clk);
      #1 d_req = 0; bus_gnt = 1;
      @(negedge clk);
      chk_val("tmo_grant_norv", {63'd0, d_rvalid}, 64'd0);
      for (int k = 1; k < TB_TIMEOUT; k++) begin
         @(posedge clk);
         #1 bus_gnt = 0;
         @(negedge clk);
         chk_val($sformatf("tmo_wait%0d", k), {62'd0, d_rvalid, d_err}, 64'd0);
      end
      @(posedge clk);
      @(negedge clk);
      chk_val("tmo_fire", {d_rdata[61:0], d_rvalid, d_err}, 64'd3);
      @(posedge clk);
      @(negedge clk);
      chk_val("tmo_idle", {61'd0, d_rvalid, mem_state}, 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one memory bus between instruction fetch (IFP stage) and data access (MEMP/MEMR stages). It holds at most one outstanding transaction, arbitrates with data priority plus a fetch anti-starvation rule, routes responses back to the owner, and produces the 2-bit `mem_state` that the hazard unit ORs into its pipeline-wide memory-busy stall.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data bus width; fetch uses low 32 bits
- `TIMEOUT`, 255, watchdog limit in cycles (used only with timeout feature)

- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `if_req` in 1, `if_addr` in ADDR_W: fetch request, payload stable while `if_req`=1 and `if_ready`=0
- `if_ready` out 1: fetch request captured (1-cycle pulse)
- `if_rvalid` out 1, `if_rdata` out 32, `if_err` out 1: fetch response
- `d_req` in 1, `d_we` in 1, `d_addr` in ADDR_W, `d_wdata` in DATA_W, `d_wstrb` in DATA_W/8: data request
- `d_ready` out 1: data request captured (1-cycle pulse)
- `d_rvalid` out 1, `d_rdata` out DATA_W, `d_err` out 1: data response; for writes `d_rvalid` is the write acknowledge
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out ADDR_W, `bus_wdata` out DATA_W, `bus_wstrb` out DATA_W/8: downstream request, registered
- `bus_gnt` in 1: slave accepted request
- `bus_rvalid` in 1, `bus_rdata` in DATA_W: slave response (also write ack)
- `mem_state` out 2: data-side status to hazard unit

## Operation
- FSM states: IDLE, GRANT_IF, GRANT_D, WAIT_IF, WAIT_D.
- IDLE: sample requests. Both pending → data wins, unless the last completed grant was data, then fetch wins. Only one pending → it wins. Winner's payload latched into bus registers, winner's `*_ready` pulses this cycle, next state GRANT_x. Fetch latches `bus_we`=0, `bus_wstrb`=0.
- GRANT_x: `bus_req`=1 with latched payload; `bus_gnt`=1 → WAIT_x, `bus_req` drops next cycle.
- WAIT_x: `bus_rvalid`=1 → owner's `*_rvalid`=1 the same cycle (combinational route), `if_rdata`=`bus_rdata[31:0]` or `d_rdata`=`bus_rdata`; next state IDLE. Non-owner `*_rvalid` stays 0.
- `bus_rvalid` outside WAIT_x is ignored.
- `mem_state` (combinational): 2'b00 no data op, or `d_rvalid`=1 this cycle; 2'b01 `d_req`=1 and not yet captured (includes the capture cycle); 2'b10 GRANT_D; 2'b11 WAIT_D without `bus_rvalid`.
- Fetch never drives `mem_state` non-zero.
- Reset (async, any state, including mid-transaction): IDLE, last-grant flag = fetch, all outputs 0. The in-flight bus transaction is abandoned; the slave shares `rst`.

## Timing
- Minimum transaction: 3 cycles (IDLE capture, GRANT with `bus_gnt`, WAIT with `bus_rvalid`).
- Back-to-back: next capture occurs in the IDLE cycle after the response; no overlap.
- Worst-case data wait behind fetch: one full fetch transaction.
- Request payload need only be stable until the `*_ready` pulse.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - Cycle counter clears on entry to GRANT_x and counts through GRANT_x/WAIT_x.
  - When it reaches `TIMEOUT` with no `bus_rvalid`: `bus_req` drops, owner gets a `*_rvalid` pulse with `*_err`=1 and rdata=0, state → IDLE.
  - A `bus_rvalid` arriving in the timeout cycle takes precedence and returns `err`=0.
- Not defined: no counter; `if_err`=`d_err`=0 constantly; `TIMEOUT` ignored.

## Structure
- Shared package `mem_pkg`:
  - `arb_state_t` enum.
  - `mem_state` encodings `MEM_ST_IDLE`, `MEM_ST_PEND`, `MEM_ST_GRANT`, `MEM_ST_WAIT`; the hazard unit uses the same constants.
- Sub-module `mem_arb_timer` (clear/enable/expire counter), instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Fetch only, `if_addr`=0x1000, `bus_gnt` in GRANT, `bus_rvalid` 2 cycles later with `bus_rdata`=0x00000013 → `if_ready` at cycle 0, `if_rvalid`/`if_rdata`=0x13 at cycle 3, `mem_state`=00 throughout.
- Both requests in the same IDLE cycle after reset → data captured first (`d_ready`); fetch captured in the IDLE after `d_rvalid`. Both again → fetch wins (anti-starvation).
- Data write `d_addr`=0x8000_0000, `d_wstrb`=0x0F while fetch in WAIT_IF → `mem_state`=01 until capture, then 10, then 11, then 00 on the `d_rvalid` cycle; `bus_we`=1 and `bus_wstrb`=0x0F in GRANT_D.
- `bus_gnt` delayed 5 cycles → `bus_req` and payload held stable for all 5 cycles.
- `rst` pulsed in WAIT_D → all outputs 0 immediately; a later stray `bus_rvalid` produces no `d_rvalid`.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=8, slave silent → `d_rvalid`=1, `d_err`=1, `d_rdata`=0 once the count reaches 8; FSM back in IDLE.
